// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline controller for the 5-stage core. Generates per-stage stall and
// flush controls, detects masked external interrupts, sequences exception
// entry / exception return off the MEM stage and owns the control registers.
// State updates happen on the falling edge of clk, in step with the pipeline
// registers.
//
// Ports
//   clk            system clock (state updates on negedge)
//   reset          asynchronous reset, active low
//   if_busy        instruction bus busy
//   mem_busy       data bus busy
//   ld_hazard      load-use hazard from decode
//   mem_pc         word PC of the instruction in MEM
//   mem_en         MEM instruction valid
//   mem_br_flag    MEM instruction sits in a branch delay slot
//   mem_ctrl_op    0 NOP, 1 WRCR, 2 EXRT
//   mem_dst_addr   control register index written by WRCR
//   mem_exp_code   exception code carried by the MEM instruction (0 = none)
//   mem_out        WRCR write data
//   irq            asynchronous level interrupt lines
//   creg_rd_addr   control register read index
//   creg_rd_data   combinational control register read data
//   *_stall        per-stage hold
//   *_flush        per-stage bubble insert
//   new_pc         redirect target (word address), valid while if_flush = 1
//   int_detect     interrupt request towards the EX register
//   exe_mode       0 = kernel, 1 = user
//
// Control register map (byte-aligned view on creg_rd_data)
//   0 STATUS      {exe_mode, int_en}
//   1 PRE_STATUS  {exe_mode, int_en}
//   2 INT_MASK    [7:0]
//   3 EXP_VECTOR  [31:2]
//   4 EPC         [31:2]
//   5 EXP_CODE    {dly, code[2:0]}
// ---------------------------------------------------------------------------
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic [29:0] mem_pc,
  input  logic        mem_en,
  input  logic        mem_br_flag,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [4:0]  mem_dst_addr,
  input  logic [2:0]  mem_exp_code,
  input  logic [31:0] mem_out,
  input  logic [7:0]  irq,
  input  logic [4:0]  creg_rd_addr,
  output logic [31:0] creg_rd_data,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [29:0] new_pc,
  output logic        int_detect,
  output logic        exe_mode
);

  localparam logic [1:0] CTRL_WRCR = 2'd1;
  localparam logic [1:0] CTRL_EXRT = 2'd2;
  localparam logic [2:0] NO_EXP    = 3'd0;

  localparam logic [4:0] CREG_STATUS     = 5'd0;
  localparam logic [4:0] CREG_PRE_STATUS = 5'd1;
  localparam logic [4:0] CREG_INT_MASK   = 5'd2;
  localparam logic [4:0] CREG_EXP_VECTOR = 5'd3;
  localparam logic [4:0] CREG_EPC        = 5'd4;
  localparam logic [4:0] CREG_EXP_CODE   = 5'd5;

  typedef enum logic {ST_RUN, ST_REDIRECT} state_t;

  state_t      state;
  logic        status_int_en;
  logic        status_exe_mode;
  logic        pre_int_en;
  logic        pre_exe_mode;
  logic [7:0]  int_mask;
  logic [29:0] exp_vector;
  logic [29:0] epc;
  logic [2:0]  exp_code;
  logic        exp_dly;
  logic [7:0]  irq_meta;
  logic [7:0]  irq_sync;

  logic stall;
  logic mem_act;
  logic exp_take;
  logic exrt_take;
  logic wrcr_take;
  logic flush_all;

  // A MEM event only acts when the pipe moves and we are not sitting in the
  // cycle right after a redirect (MEM then holds the squashed instruction).
  assign stall     = if_busy | mem_busy;
  assign mem_act   = mem_en & ~stall & (state == ST_RUN);
  assign exp_take  = mem_act & (mem_exp_code != NO_EXP);
  assign exrt_take = mem_act & (mem_exp_code == NO_EXP) & (mem_ctrl_op == CTRL_EXRT);
  assign wrcr_take = mem_act & (mem_exp_code == NO_EXP) & (mem_ctrl_op == CTRL_WRCR);
  assign flush_all = exp_take | exrt_take;

  assign if_stall  = stall | ld_hazard;
  assign id_stall  = stall;
  assign ex_stall  = stall;
  assign mem_stall = stall;

  // id_flush also turns a load-use hazard into a bubble heading for EX.
  assign if_flush  = flush_all;
  assign id_flush  = flush_all | (ld_hazard & ~stall);
  assign ex_flush  = flush_all;
  assign mem_flush = flush_all;

  assign new_pc = exp_take ? exp_vector : (exrt_take ? epc : 30'd0);

  assign int_detect = (state == ST_RUN) & status_int_en & (|(irq_sync & int_mask));
  assign exe_mode   = status_exe_mode;

  always_comb begin
    creg_rd_data = 32'd0;
    case (creg_rd_addr)
      CREG_STATUS:     creg_rd_data = {30'd0, status_exe_mode, status_int_en};
      CREG_PRE_STATUS: creg_rd_data = {30'd0, pre_exe_mode, pre_int_en};
      CREG_INT_MASK:   creg_rd_data = {24'd0, int_mask};
      CREG_EXP_VECTOR: creg_rd_data = {exp_vector, 2'b00};
      CREG_EPC:        creg_rd_data = {epc, 2'b00};
      CREG_EXP_CODE:   creg_rd_data = {28'd0, exp_dly, exp_code};
      default:         creg_rd_data = 32'd0;
    endcase
  end

  // Exception entry saves the delay-slot branch PC (mem_pc - 1) so that
  // return re-executes the branch; subtraction wraps in 30 bits.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_RUN;
      status_int_en   <= 1'b0;
      status_exe_mode <= 1'b0;
      pre_int_en      <= 1'b0;
      pre_exe_mode    <= 1'b0;
      int_mask        <= 8'd0;
      exp_vector      <= 30'd0;
      epc             <= 30'd0;
      exp_code        <= 3'd0;
      exp_dly         <= 1'b0;
      irq_meta        <= 8'd0;
      irq_sync        <= 8'd0;
    end else begin
      irq_meta <= irq;
      irq_sync <= irq_meta;

      case (state)
        ST_RUN:      if (flush_all) state <= ST_REDIRECT;
        ST_REDIRECT: if (!stall)    state <= ST_RUN;
        default:                    state <= ST_RUN;
      endcase

      if (exp_take) begin
        exp_code        <= mem_exp_code;
        exp_dly         <= mem_br_flag;
        epc             <= mem_br_flag ? (mem_pc - 30'd1) : mem_pc;
        pre_int_en      <= status_int_en;
        pre_exe_mode    <= status_exe_mode;
        status_int_en   <= 1'b0;
        status_exe_mode <= 1'b0;
      end else if (exrt_take) begin
        status_int_en   <= pre_int_en;
        status_exe_mode <= pre_exe_mode;
      end else if (wrcr_take) begin
        case (mem_dst_addr)
          CREG_STATUS: begin
            status_int_en   <= mem_out[0];
            status_exe_mode <= mem_out[1];
          end
          CREG_PRE_STATUS: begin
            pre_int_en   <= mem_out[0];
            pre_exe_mode <= mem_out[1];
          end
          CREG_INT_MASK:   int_mask   <= mem_out[7:0];
          CREG_EXP_VECTOR: exp_vector <= mem_out[31:2];
          CREG_EPC:        epc        <= mem_out[31:2];
          CREG_EXP_CODE: begin
            exp_code <= mem_out[2:0];
            exp_dly  <= mem_out[3];
          end
          default: ;
        endcase
      end
    end
  end

endmodule
